// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
// Holds the FSM state enum, default parameter values and the stat counter width.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int DWIDTH_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int STAT_W        = 16;
  localparam int BCNT_W        = 4;

  // Saturating increment for the per-requester beat statistics.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: searches the request mask starting one
// position after the last owner and returns a one-hot winner, its index and a valid flag.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    // k=NREQ wraps back to the last owner itself, so it only wins when alone.
    for (int k = 1; k <= NREQ; k++) begin
      w_j = (int'(i_last) + k) % NREQ;
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a single FIFO: grants one requester at a
// time for bursts of up to MAX_BURST beats. Optional stats via FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  input  logic                     full,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr,
  output logic [DWIDTH-1:0]        data_in,
  output logic [NREQ*STAT_W-1:0]   stat_beats
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt, w_gnt_nxt;
  logic [IW-1:0]     r_last, w_last_nxt;   // current owner while in OWN
  logic [BCNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [NREQ-1:0]   w_mask;
  logic [NREQ-1:0]   w_pick_gnt;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_vld;
  logic              w_rel;

  // On release the outgoing owner is excluded so another requester gets a turn.
  assign w_mask = (r_state == OWN) ? (req & ~r_gnt) : req;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req  (w_mask),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_vld)
  );

  assign w_rel = (wr && (req_last[r_last] || (r_cnt == BCNT_W'(MAX_BURST - 1))))
               || !req[r_last];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= IW'(NREQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = OWN;
          w_gnt_nxt   = w_pick_gnt;
          w_last_nxt  = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (w_rel) begin
          w_cnt_nxt = '0;
          if (w_pick_vld) begin
            w_gnt_nxt  = w_pick_gnt;
            w_last_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (wr) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    wr      = (|(r_gnt & req)) & ~full;
    data_in = '0;
    if (|r_gnt) data_in = req_data[int'(r_last)*DWIDTH +: DWIDTH];
  end

  assign gnt = r_gnt;

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [STAT_W-1:0] r_stat;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_stat <= '0;
      else if (wr && r_gnt[g]) r_stat <= sat_inc(r_stat);
    end
    assign stat_beats[g*STAT_W +: STAT_W] = r_stat;
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (default parameters).
// Stat checks adapt to whether FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arb;
  import fifo_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*DW-1:0]     req_data = '0;
  logic [NREQ-1:0]        req_last = '0;
  logic                   full = 1'b0;
  logic [NREQ-1:0]        gnt;
  logic                   wr;
  logic [DW-1:0]          data_in;
  logic [NREQ*STAT_W-1:0] stat_beats;

  int errs   = 0;
  int checks = 0;
  logic [DW-1:0] fifo_q[$];
  int bcnt[NREQ];

  fifo_wr_arb #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .full       (full),
    .gnt        (gnt),
    .wr         (wr),
    .data_in    (data_in),
    .stat_beats (stat_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model FIFO and per-requester beat counts, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      if (wr) begin
        fifo_q.push_back(data_in);
        for (int i = 0; i < NREQ; i++) if (gnt[i]) bcnt[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; req_last = '0; full = 1'b0;
    step();
    step();
    rst = 1'b1;
    fifo_q.delete();
    for (int i = 0; i < NREQ; i++) bcnt[i] = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] got3;
    int n, cyc, own;

    // Reset state, with requests asserted
    req = 4'hF;
    #12;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_data", 64'(data_in), 64'd0);
    chk("rst_stat", 64'(stat_beats), 64'd0);
    do_reset();

    // Single requester, 3-beat burst ending on req_last
    req = 4'b0001; req_data[7:0] = 8'hA1;
    #1 chk("t29_gnt_pre", 64'(gnt), 64'd0);
    step();
    chk("t29_gnt", 64'(gnt), 64'b0001);
    chk("t29_wr1", 64'(wr), 64'd1);
    chk("t29_d1", 64'(data_in), 64'hA1);
    step();
    req_data[7:0] = 8'hA2;
    #1 chk("t29_d2", 64'(data_in), 64'hA2);
    step();
    req_data[7:0] = 8'hA3; req_last = 4'b0001;
    #1 chk("t29_wr3", 64'(wr), 64'd1);
    step();
    req = '0; req_last = '0;
    #1 chk("t29_idle_gnt", 64'(gnt), 64'd0);
    chk("t29_idle_wr", 64'(wr), 64'd0);
    step();
    chk("t29_fifo_n", 64'(fifo_q.size()), 64'd3);
    got3 = '0;
    for (int i = 0; i < fifo_q.size() && i < 3; i++) got3[i*8 +: 8] = fifo_q[i];
    chk("t29_fifo", 64'(got3), 64'hA3A2A1);

    // All requesting: rotation with MAX_BURST beats each, no gaps
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'hD0 + 8'(i);
    req = 4'hF;
    step();
    for (int k = 0; k < 20; k++) begin
      own = (k / 4) % 4;
      chk($sformatf("t30_gnt_%0d", k), 64'(gnt), 64'd1 << own);
      chk($sformatf("t30_wr_%0d", k), 64'(wr), 64'd1);
      chk($sformatf("t30_d_%0d", k), 64'(data_in), 64'hD0 + 64'(own));
      step();
    end
    chk("t30_bcnt0", 64'(bcnt[0]), 64'd8);
    chk("t30_bcnt3", 64'(bcnt[3]), 64'd4);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("t30_stat", 64'(stat_beats), {16'd4, 16'd4, 16'd4, 16'd8});
`else
    chk("t30_stat_off", 64'(stat_beats), 64'd0);
`endif

    // Stall on full mid-burst: hold grant, stalls do not count
    do_reset();
    req = 4'b0100; req_data[16 +: 8] = 8'h5A;
    step();
    chk("t31_gnt", 64'(gnt), 64'b0100);
    chk("t31_wr_a", 64'(wr), 64'd1);
    step();
    #1 chk("t31_wr_b", 64'(wr), 64'd1);
    step();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t31_stall_wr_%0d", k), 64'(wr), 64'd0);
      chk($sformatf("t31_stall_gnt_%0d", k), 64'(gnt), 64'b0100);
      step();
    end
    full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk($sformatf("t31_res_wr_%0d", k), 64'(wr), 64'd1);
      chk($sformatf("t31_res_gnt_%0d", k), 64'(gnt), 64'b0100);
      step();
    end
    chk("t31_rel", 64'(gnt), 64'd0);
    chk("t31_beats", 64'(bcnt[2]), 64'd4);
    req = '0;

    // Reset during the 2nd beat of requester 1
    do_reset();
    req = 4'b0010; req_data[8 +: 8] = 8'h11;
    step();
    chk("t32_gnt", 64'(gnt), 64'b0010);
    step();
    #1 chk("t32_wr_b2", 64'(wr), 64'd1);
    rst = 1'b0;
    #1 chk("t32_rst_gnt", 64'(gnt), 64'd0);
    chk("t32_rst_wr", 64'(wr), 64'd0);
    req = 4'hF;
    step();
    step();
    chk("t32_hold_gnt", 64'(gnt), 64'd0);
    rst = 1'b1;
    step();
    chk("t32_first", 64'(gnt), 64'b0001);
    chk("t32_beats1", 64'(bcnt[1]), 64'd1);
    req = '0;

    // Owner drops request: immediate handover with no idle cycle
    do_reset();
    req = 4'b1000; req_data[24 +: 8] = 8'h33; req_data[7:0] = 8'h0A;
    step();
    chk("t33_gnt3", 64'(gnt), 64'b1000);
    chk("t33_d3", 64'(data_in), 64'h33);
    step();
    req = 4'b0001;
    #1 chk("t33_drop_wr", 64'(wr), 64'd0);
    step();
    chk("t33_gnt0", 64'(gnt), 64'b0001);
    chk("t33_wr0", 64'(wr), 64'd1);
    chk("t33_d0", 64'(data_in), 64'h0A);
    req = '0;

    // Statistics saturation
    do_reset();
`ifdef FIFO_WR_ARB_STATS_EN
    req = 4'b0001;
    n = 0; cyc = 0;
    while (n < 70000 && cyc < 89000) begin
      @(negedge clk);
      if (wr) n++;
      cyc++;
    end
    @(posedge clk);
    #1 req = '0;
    fifo_q.delete();
    chk("t34_beats", 64'(n), 64'd70000);
    step();
    chk("t34_sat", 64'(stat_beats), 64'h0000_0000_0000_FFFF);
`else
    req = 4'b0011;
    for (int k = 0; k < 12; k++) step();
    req = '0;
    step();
    chk("t34_stat_off", 64'(stat_beats), 64'd0);
    chk("t34_beats_seen", 64'(bcnt[0] > 0 && bcnt[1] > 0), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
